banner_rotate_ctrl: RTL and testbench
=====================================

Name: banner_rotate_ctrl

Overview:
- Sequencer for the 4-digit rotating number banner.
- Turns single-cycle user command pulses (start/stop, direction, speed, clear) into a run/pause/idle state machine.
- Generates a programmable-rate step strobe plus a stable direction output, which the banner shift datapath consumes to advance one digit per step.
- Sits between the button debouncers/edge detectors and the banner shift register.

Parameters:
- CLK_DIV_BASE, 12_500_000, clock cycles between steps at the fastest speed (speed 3); must be >= 2.
- CNT_W, 28, timer counter width; must satisfy 2^CNT_W > 8*CLK_DIV_BASE.
- BOUNCE_STEPS, 8, steps per direction before auto-reverse (used only with the optional feature); must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_stop  in  1  one-cycle pulse: toggles between run and pause; also starts from idle.
- dir_toggle  in  1  one-cycle pulse: inverts rotation direction.
- speed_next  in  1  one-cycle pulse: advances speed 0→1→2→3→0.
- clear  in  1  one-cycle pulse: returns the block to idle with defaults.
- step  out  1  one-cycle strobe: the datapath shifts exactly once per high cycle.
- dir  out  1  1 = shift left/increment, 0 = shift right/decrement.
- running  out  1  high only in RUN.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE (11 never driven).
- speed  out  2  current speed level, 0 slowest.
- clear_out  out  1  one-cycle pulse, registered copy of an accepted clear, used to zero the datapath.

Behaviour:
- Reset values: state=IDLE, step=0, dir=1, running=0, speed=0, clear_out=0, timer=0, bounce count=0. All outputs are registered.
- Step period P = CLK_DIV_BASE << (3 - speed).
  - speed 0: 8*BASE cycles.
  - speed 3: BASE cycles.
- FSM transitions:
  - IDLE: start_stop → RUN. All other pulses except clear are still applied to dir/speed.
  - RUN: start_stop → PAUSE.
  - PAUSE: start_stop → RUN.
  - Any state: clear → IDLE.
- Timer:
  - Counts only in RUN.
  - When timer == P-1: timer ← 0 and step=1 in the next cycle. First step after entering RUN from IDLE comes exactly P cycles after the cycle in which start_stop was sampled.
  - PAUSE: timer holds; resuming continues from the held value.
  - IDLE: timer = 0.
  - step never asserts outside RUN. A step already registered when start_stop is sampled still completes its one-cycle pulse.
- dir_toggle: dir inverts in the next cycle. If it coincides with the timer terminal count, the step pulse is issued and the new dir is valid in the same cycle as that step.
- speed_next: speed ← speed+1 mod 4 in the next cycle; timer cleared to 0, so no step is issued on that cycle.
- clear:
  - Highest priority; all other pulses in the same cycle are ignored.
  - Next cycle: state=IDLE, dir=1, speed=0, timer=0, step=0, clear_out=1 for one cycle.
- Simultaneous start_stop, dir_toggle and speed_next in one cycle: all three are applied.
- Asynchronous reset at any time (mid-run or mid-step) forces reset values immediately, including dropping step.

Optional Feature:
- Macro: BANNER_AUTO_BOUNCE_EN.
- Defined:
  - A step counter counts issued steps since the last direction change.
  - When the BOUNCE_STEPS-th step is issued, dir inverts in the following cycle and the counter clears.
  - Manual dir_toggle also clears the counter.
  - A manual toggle coinciding with an auto flip gives a single net inversion.
  - Counter clears on clear/reset and holds in PAUSE.
- Undefined: no counter; dir changes only on dir_toggle, clear or reset.

Test Plan (CLK_DIV_BASE=4, BOUNCE_STEPS=3):
- Reset, then start_stop at cycle 0 → running=1; step pulses at cycles 32, 64, 96 (speed 0); dir=1 throughout.
- speed_next ×3 while in IDLE, then start_stop → speed=3; steps every 4 cycles; 4th speed_next → speed=0, step period 32.
- RUN 20 cycles, start_stop (pause) for 50 cycles, start_stop again → no step while paused; next step 12 cycles after resume.
- dir_toggle on the terminal-count cycle → step pulse with dir=0 in the same cycle; subsequent steps keep dir=0.
- clear together with start_stop in RUN at speed 2 → next cycle state=IDLE, clear_out=1 for exactly 1 cycle, dir=1, speed=0, no further steps.
- With BANNER_AUTO_BOUNCE_EN: run at speed 3 → dir flips after steps 3, 6, 9; a dir_toggle at step 2 resets the count so the next auto flip follows step 5.

Source files
------------

// File: rtl/banner_rotate_ctrl.sv
// Run/pause/idle sequencer for the rotating number banner: turns command pulses into a step strobe and a direction.
// Optional auto-reverse after a fixed number of steps is enabled with BANNER_AUTO_BOUNCE_EN.
module banner_rotate_ctrl #(
    parameter int CLK_DIV_BASE = 12_500_000,
    parameter int CNT_W        = 28,
    parameter int BOUNCE_STEPS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       dir_toggle,
    input  logic       speed_next,
    input  logic       clear,
    output logic       step,
    output logic       dir,
    output logic       running,
    output logic [1:0] state,
    output logic [1:0] speed,
    output logic       clear_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    if (CLK_DIV_BASE < 2 || BOUNCE_STEPS < 1) begin : g_param_check
        $error("banner_rotate_ctrl: CLK_DIV_BASE must be >= 2 and BOUNCE_STEPS >= 1");
    end

    state_t           cur_state;
    state_t           next_state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_d;
    logic [CNT_W-1:0] period_last;
    logic             step_d;
    logic             dir_d;
    logic             running_d;
    logic [1:0]       speed_d;
    logic             clear_out_d;

`ifdef BANNER_AUTO_BOUNCE_EN
    localparam int BW = (BOUNCE_STEPS < 2) ? 1 : $clog2(BOUNCE_STEPS);
    logic [BW-1:0] bounce;
    logic [BW-1:0] bounce_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        if (clear) begin
            next_state = IDLE;
        end else if (start_stop) begin
            case (cur_state)
                IDLE:    next_state = RUN;
                RUN:     next_state = PAUSE;
                PAUSE:   next_state = RUN;
                default: next_state = IDLE;
            endcase
        end
    end

    // Terminal count of the step period: BASE cycles at speed 3, doubling per level below.
    assign period_last = (CNT_W'(CLK_DIV_BASE) << (2'd3 - speed)) - CNT_W'(1);

    // The timer advances in every cycle whose successor is RUN, so the first step lands
    // exactly one period after the start_stop cycle and resuming continues seamlessly.
    always_comb begin
        timer_d     = timer;
        step_d      = 1'b0;
        dir_d       = dir;
        speed_d     = speed;
        clear_out_d = 1'b0;
        running_d   = (next_state == RUN);
`ifdef BANNER_AUTO_BOUNCE_EN
        bounce_d    = bounce;
`endif
        if (clear) begin
            timer_d     = '0;
            dir_d       = 1'b1;
            speed_d     = 2'd0;
            clear_out_d = 1'b1;
`ifdef BANNER_AUTO_BOUNCE_EN
            bounce_d    = '0;
`endif
        end else begin
            if (next_state == RUN) begin
                if (timer == period_last) begin
                    timer_d = '0;
                    step_d  = 1'b1;
                end else begin
                    timer_d = timer + CNT_W'(1);
                end
            end else if (next_state == IDLE) begin
                timer_d = '0;
            end
            if (speed_next) begin
                speed_d = speed + 2'd1;
                timer_d = '0;
                step_d  = 1'b0;
            end
            if (dir_toggle) begin
                dir_d = ~dir;
            end
`ifdef BANNER_AUTO_BOUNCE_EN
            if (dir_toggle) begin
                bounce_d = '0;
            end
            // An auto flip that coincides with a manual toggle still inverts only once.
            if (step) begin
                if (bounce == BW'(BOUNCE_STEPS - 1)) begin
                    dir_d    = ~dir;
                    bounce_d = '0;
                end else if (!dir_toggle) begin
                    bounce_d = bounce + BW'(1);
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer     <= '0;
            step      <= 1'b0;
            dir       <= 1'b1;
            running   <= 1'b0;
            speed     <= 2'd0;
            clear_out <= 1'b0;
`ifdef BANNER_AUTO_BOUNCE_EN
            bounce    <= '0;
`endif
        end else begin
            timer     <= timer_d;
            step      <= step_d;
            dir       <= dir_d;
            running   <= running_d;
            speed     <= speed_d;
            clear_out <= clear_out_d;
`ifdef BANNER_AUTO_BOUNCE_EN
            bounce    <= bounce_d;
`endif
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_banner_rotate_ctrl.sv
// Scoreboard bench for banner_rotate_ctrl: directed scenarios plus random command pulses against a behavioural model.
module tb_banner_rotate_ctrl;

    localparam int BASE   = 4;
    localparam int CNT_W  = 8;
    localparam int BOUNCE = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_stop;
    logic       dir_toggle;
    logic       speed_next;
    logic       clear;
    logic       step;
    logic       dir;
    logic       running;
    logic [1:0] state;
    logic [1:0] speed;
    logic       clear_out;

    typedef struct packed {
        logic       step;
        logic       dir;
        logic       running;
        logic [1:0] state;
        logic [1:0] speed;
        logic       clear_out;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Model: mode 0 idle, 1 run, 2 pause; progress counts run cycles since the last step.
    int m_mode;
    int m_progress;
    int m_speed;
    int m_bounce;
    bit m_dir;
    bit m_step;

    always #5 clk = ~clk;

    banner_rotate_ctrl #(
        .CLK_DIV_BASE(BASE),
        .CNT_W(CNT_W),
        .BOUNCE_STEPS(BOUNCE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_stop(start_stop),
        .dir_toggle(dir_toggle),
        .speed_next(speed_next),
        .clear(clear),
        .step(step),
        .dir(dir),
        .running(running),
        .state(state),
        .speed(speed),
        .clear_out(clear_out)
    );

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_mode     = 0;
        m_progress = 0;
        m_speed    = 0;
        m_bounce   = 0;
        m_dir      = 1'b1;
        m_step     = 1'b0;
    endtask

    task automatic model_cycle(input bit ss, input bit dt, input bit sn, input bit cl, output exp_t e);
        int next_mode;
        int period;
        bit auto_flip;
        if (cl) begin
            model_reset();
        end else begin
            next_mode = !ss ? m_mode : ((m_mode == 1) ? 2 : 1);
            period    = BASE * 8 / (1 << m_speed);
            auto_flip = 1'b0;
`ifdef BANNER_AUTO_BOUNCE_EN
            auto_flip = m_step && (m_bounce + 1 == BOUNCE);
            if (dt || auto_flip) m_bounce = 0;
            else if (m_step) m_bounce++;
`endif
            m_step = 1'b0;
            if (next_mode == 1) begin
                m_progress++;
                if (m_progress == period) begin
                    m_step     = 1'b1;
                    m_progress = 0;
                end
            end
            if (sn) begin
                m_speed    = (m_speed + 1) % 4;
                m_progress = 0;
                m_step     = 1'b0;
            end
            if (dt || auto_flip) m_dir = !m_dir;
            m_mode = next_mode;
        end
        e.step      = m_step;
        e.dir       = m_dir;
        e.running   = (m_mode == 1);
        e.state     = 2'(m_mode);
        e.speed     = 2'(m_speed);
        e.clear_out = cl;
    endtask

    task automatic apply_stimulus(input bit ss, input bit dt, input bit sn, input bit cl);
        exp_t e;
        @(negedge clk);
        start_stop = ss;
        dir_toggle = dt;
        speed_next = sn;
        clear      = cl;
        model_cycle(ss, dt, sn, cl, e);
        sb_q.push_back(e);
        mon_en = 1'b1;
    endtask

    task automatic cycle_sample(input bit ss, input bit dt, input bit sn, input bit cl, output bit s);
        apply_stimulus(ss, dt, sn, cl);
        @(posedge clk);
        #1;
        s = step;
    endtask

    task automatic wait_step(input int limit, output int n);
        bit s;
        n = 0;
        do begin
            cycle_sample(1'b0, 1'b0, 1'b0, 1'b0, s);
            n++;
        end while (!s && n < limit);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_output("reset_step", step, 0);
        check_output("reset_state", state, 0);
        check_output("reset_running", running, 0);
        check_output("reset_dir", dir, 1);
        check_output("reset_speed", speed, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        sb_q.delete();
    endtask

    // Monitor: every output cycle is compared against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (sb_q.size() == 0) begin
                    check_output("sb_underflow", 0, 1);
                end else begin
                    e = sb_q.pop_front();
                    check_output("sb_step", step, e.step);
                    check_output("sb_dir", dir, e.dir);
                    check_output("sb_running", running, e.running);
                    check_output("sb_state", state, e.state);
                    check_output("sb_speed", speed, e.speed);
                    check_output("sb_clear_out", clear_out, e.clear_out);
                end
            end
        end
    end

    initial begin
        bit s;
        int n;
        int seen;
        bit rst_done;
        start_stop = 1'b0;
        dir_toggle = 1'b0;
        speed_next = 1'b0;
        clear      = 1'b0;
        reset      = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_step", step, 0);
        check_output("rst_dir", dir, 1);
        check_output("rst_running", running, 0);
        check_output("rst_state", state, 0);
        check_output("rst_speed", speed, 0);
        check_output("rst_clear_out", clear_out, 0);
        @(negedge clk);
        reset = 1'b0;

        // Start from idle at speed 0: steps 32 cycles apart, first one 32 after start.
        cycle_sample(1'b1, 1'b0, 1'b0, 1'b0, s);
        check_output("start_running", running, 1);
        wait_step(100, n);
        check_output("first_step_latency", n + 1, 32);
        wait_step(100, n);
        check_output("speed0_gap", n, 32);
        wait_step(100, n);
        check_output("speed0_gap2", n, 32);
`ifndef BANNER_AUTO_BOUNCE_EN
        check_output("speed0_dir", dir, 1);
`endif
        cycle_sample(1'b0, 1'b0, 1'b0, 1'b1, s);

        // Pause after 20 run cycles, hold 50, resume: next step 12 cycles after resume.
        cycle_sample(1'b1, 1'b0, 1'b0, 1'b0, s);
        repeat (19) cycle_sample(1'b0, 1'b0, 1'b0, 1'b0, s);
        cycle_sample(1'b1, 1'b0, 1'b0, 1'b0, s);
        check_output("pause_state", state, 2);
        seen = 0;
        repeat (49) begin
            cycle_sample(1'b0, 1'b0, 1'b0, 1'b0, s);
            if (s) seen++;
        end
        check_output("pause_no_step", seen, 0);
        cycle_sample(1'b1, 1'b0, 1'b0, 1'b0, s);
        wait_step(100, n);
        check_output("resume_latency", n + 1, 12);
        cycle_sample(1'b0, 1'b0, 1'b0, 1'b1, s);

        // Speed 3 from idle, then a dir toggle on the terminal-count cycle.
        repeat (3) cycle_sample(1'b0, 1'b0, 1'b1, 1'b0, s);
        check_output("idle_speed3", speed, 3);
        cycle_sample(1'b1, 1'b0, 1'b0, 1'b0, s);
        wait_step(100, n);
        check_output("speed3_first", n + 1, 4);
        wait_step(100, n);
        check_output("speed3_gap", n, 4);
        repeat (3) cycle_sample(1'b0, 1'b0, 1'b0, 1'b0, s);
        cycle_sample(1'b0, 1'b1, 1'b0, 1'b0, s);
        check_output("dt_tc_step", s, 1);
`ifndef BANNER_AUTO_BOUNCE_EN
        check_output("dt_tc_dir", dir, 0);
        wait_step(100, n);
        check_output("dt_after_dir", dir, 0);
`endif

        // Fourth speed_next wraps to speed 0.
        cycle_sample(1'b0, 1'b0, 1'b1, 1'b0, s);
        check_output("wrap_speed", speed, 0);
        check_output("wrap_no_step", s, 0);
        wait_step(100, n);
        check_output("wrap_first", n, 32);
        wait_step(100, n);
        check_output("wrap_gap", n, 32);

        // Clear together with start_stop while running at speed 2.
        repeat (2) cycle_sample(1'b0, 1'b0, 1'b1, 1'b0, s);
        check_output("speed2", speed, 2);
        cycle_sample(1'b1, 1'b0, 1'b0, 1'b1, s);
        check_output("clr_state", state, 0);
        check_output("clr_pulse", clear_out, 1);
        check_output("clr_dir", dir, 1);
        check_output("clr_speed", speed, 0);
        cycle_sample(1'b0, 1'b0, 1'b0, 1'b0, s);
        check_output("clr_pulse_end", clear_out, 0);
        seen = 0;
        repeat (40) begin
            cycle_sample(1'b0, 1'b0, 1'b0, 1'b0, s);
            if (s) seen++;
        end
        check_output("clr_no_step", seen, 0);

        // Random command pulses, with one asynchronous reset landing on a step pulse.
        rst_done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!rst_done && i > 1000 && m_step) begin
                mid_reset();
                rst_done = 1'b1;
            end
            apply_stimulus($urandom_range(0, 19) == 0, $urandom_range(0, 15) == 0,
                           $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
        end
        check_output("mid_step_reset_hit", rst_done, 1);

        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
